// File: rtl/lsu_pkg.sv
// Shared types and helpers for the LSU bus master: FSM states, access size codes,
// RV32 load/store funct3 encodings and the size/alignment decode.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Undefined encodings fall through to a word access.
  function automatic logic [1:0] size_of(input logic [2:0] funct3);
    logic [1:0] size;
    case (funct3)
      F3_B, F3_BU: size = SZ_B;
      F3_H, F3_HU: size = SZ_H;
      default:     size = SZ_W;
    endcase
    return size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      default: bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Execute-side request/result streams plus the io_lsu memory bus of the LSU master.
// The master modport is the LSU side; the slave modport is the execute stage / responder side.
interface lsu_bus_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_W-1:0]     in_addr;
  logic                  in_wen;
  logic [DATA_W-1:0]     in_wdata;
  logic [2:0]            in_funct3;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     out_rdata;
  logic                  out_err;
  logic                  io_lsu_reqValid;
  logic [ADDR_W-1:0]     io_lsu_addr;
  logic                  io_lsu_wen;
  logic [DATA_W-1:0]     io_lsu_wdata;
  logic [DATA_W/8-1:0]   io_lsu_wmask;
  logic [1:0]            io_lsu_size;
  logic                  io_lsu_respValid;
  logic [DATA_W-1:0]     io_lsu_rdata;

  modport master (
    input  in_valid, in_addr, in_wen, in_wdata, in_funct3, out_ready,
    input  io_lsu_respValid, io_lsu_rdata,
    output in_ready, out_valid, out_rdata, out_err,
    output io_lsu_reqValid, io_lsu_addr, io_lsu_wen, io_lsu_wdata, io_lsu_wmask, io_lsu_size
  );

  modport slave (
    output in_valid, in_addr, in_wen, in_wdata, in_funct3, out_ready,
    output io_lsu_respValid, io_lsu_rdata,
    input  in_ready, out_valid, out_rdata, out_err,
    input  io_lsu_reqValid, io_lsu_addr, io_lsu_wen, io_lsu_wdata, io_lsu_wmask, io_lsu_size
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane formatting: store lane replication + write mask, and
// load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        wen,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [1:0]  size,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] rdata
);

  logic [31:0] shifted_s;
  logic        signed_s;

  // Store path: replicate the source across lanes, the mask picks the live ones.
  always_comb begin
    size  = size_of(funct3);
    wmask = 4'b0000;
    wdata = 32'h0000_0000;
    if (wen) begin
      case (size)
        SZ_B: begin
          wmask = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        SZ_H: begin
          wmask = 4'b0011 << addr_lo;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          wmask = 4'b1111;
          wdata = store_data;
        end
      endcase
    end else begin
      wmask = 4'b0000;
      wdata = 32'h0000_0000;
    end
  end

  // Load path: bring the addressed lane down to bit 0 and extend; funct3[2] marks unsigned.
  always_comb begin
    shifted_s = load_data >> {addr_lo, 3'b000};
    signed_s  = ~funct3[2];
    rdata     = load_data;
    case (size_of(funct3))
      SZ_B:    rdata = signed_s ? {{24{shifted_s[7]}}, shifted_s[7:0]}
                                : {24'h00_0000, shifted_s[7:0]};
      SZ_H:    rdata = signed_s ? {{16{shifted_s[15]}}, shifted_s[15:0]}
                                : {16'h0000, shifted_s[15:0]};
      default: rdata = load_data;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// LSU initiator: accepts one load/store, issues a one-cycle io_lsu request, waits for the
// response (bounded by TIMEOUT) and returns the formatted result to writeback.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input logic              clock,
  input logic              reset,
  lsu_bus_master_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_e              state_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic                out_err_r;
  logic [DATA_W-1:0]   out_rdata_r;
  logic                req_valid_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                wen_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [3:0]          wmask_r;
  logic [1:0]          size_r;
  logic [2:0]          funct3_r;
  logic [CNT_W-1:0]    cnt_r;

  logic [1:0]          al_addr_s;
  logic [2:0]          al_funct3_s;
  logic                al_wen_s;
  logic [1:0]          al_size_s;
  logic [3:0]          al_wmask_s;
  logic [31:0]         al_wdata_s;
  logic [31:0]         al_rdata_s;
  logic                misaligned_s;

  // The aligner formats the incoming op while idle and the captured op afterwards.
  always_comb begin
    if (state_r == ST_IDLE) begin
      al_addr_s   = bus.in_addr[1:0];
      al_funct3_s = bus.in_funct3;
      al_wen_s    = bus.in_wen;
    end else begin
      al_addr_s   = addr_r[1:0];
      al_funct3_s = funct3_r;
      al_wen_s    = wen_r;
    end
  end

  lsu_align u_align (
    .addr_lo    (al_addr_s),
    .funct3     (al_funct3_s),
    .wen        (al_wen_s),
    .store_data (bus.in_wdata),
    .load_data  (bus.io_lsu_rdata),
    .size       (al_size_s),
    .wmask      (al_wmask_s),
    .wdata      (al_wdata_s),
    .rdata      (al_rdata_s)
  );

  assign misaligned_s = is_misaligned(al_size_s, al_addr_s);

  // Transaction FSM with all bus and result outputs registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_err_r   <= 1'b0;
      out_rdata_r <= {DATA_W{1'b0}};
      req_valid_r <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      wen_r       <= 1'b0;
      wdata_r     <= {DATA_W{1'b0}};
      wmask_r     <= 4'b0000;
      size_r      <= 2'b00;
      funct3_r    <= 3'b000;
      cnt_r       <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
            funct3_r   <= bus.in_funct3;
            if (misaligned_s) begin
              state_r     <= ST_RESP;
              out_valid_r <= 1'b1;
              out_err_r   <= 1'b1;
              out_rdata_r <= {DATA_W{1'b0}};
            end else begin
              state_r     <= ST_REQ;
              req_valid_r <= 1'b1;
              addr_r      <= bus.in_addr;
              wen_r       <= bus.in_wen;
              wdata_r     <= al_wdata_s;
              wmask_r     <= al_wmask_s;
              size_r      <= al_size_s;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_REQ: begin
          req_valid_r <= 1'b0;
          cnt_r       <= {CNT_W{1'b0}};
          state_r     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.io_lsu_respValid) begin
            state_r     <= ST_RESP;
            out_valid_r <= 1'b1;
            out_err_r   <= 1'b0;
            out_rdata_r <= wen_r ? {DATA_W{1'b0}} : al_rdata_s;
            cnt_r       <= {CNT_W{1'b0}};
          end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
            state_r     <= ST_RESP;
            out_valid_r <= 1'b1;
            out_err_r   <= 1'b1;
            out_rdata_r <= {DATA_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          req_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready        = in_ready_r;
  assign bus.out_valid       = out_valid_r;
  assign bus.out_err         = out_err_r;
  assign bus.out_rdata       = out_rdata_r;
  assign bus.io_lsu_reqValid = req_valid_r;
  assign bus.io_lsu_addr     = addr_r;
  assign bus.io_lsu_wen      = wen_r;
  assign bus.io_lsu_wdata    = wdata_r;
  assign bus.io_lsu_wmask    = wmask_r;
  assign bus.io_lsu_size     = size_r;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed bench for lsu_bus_master: stores, loads, misalignment, timeout,
// result back-pressure and asynchronous reset, with hand-computed expectations.
module tb_lsu_bus_master;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  lsu_bus_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [2:0] f3);
    bus.in_valid  = 1'b1;
    bus.in_addr   = a;
    bus.in_wen    = w;
    bus.in_wdata  = wd;
    bus.in_funct3 = f3;
    step();
    bus.in_valid  = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rd);
    bus.io_lsu_respValid = 1'b1;
    bus.io_lsu_rdata     = rd;
    step();
    bus.io_lsu_respValid = 1'b0;
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_addr = 32'h0; bus.in_wen = 1'b0; bus.in_wdata = 32'h0;
    bus.in_funct3 = 3'b000; bus.out_ready = 1'b0; bus.io_lsu_respValid = 1'b0; bus.io_lsu_rdata = 32'h0;
    #1 reset = 1'b0;
    #2;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got=%b exp=0", bus.out_err); end
    checks++; if (bus.out_rdata !== 32'h0) begin errors++; $display("FAIL reset_out_rdata got=%h exp=0", bus.out_rdata); end
    checks++; if (bus.io_lsu_reqValid !== 1'b0) begin errors++; $display("FAIL reset_reqValid got=%b exp=0", bus.io_lsu_reqValid); end
    checks++; if ({bus.io_lsu_addr, bus.io_lsu_wdata} !== 64'h0) begin errors++; $display("FAIL reset_addr_wdata got=%h/%h exp=0", bus.io_lsu_addr, bus.io_lsu_wdata); end
    checks++; if ({bus.io_lsu_wen, bus.io_lsu_wmask, bus.io_lsu_size} !== 7'b0) begin errors++; $display("FAIL reset_wen_mask_size got=%b/%b/%b exp=0", bus.io_lsu_wen, bus.io_lsu_wmask, bus.io_lsu_size); end
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_store_word();
    issue(32'h3000_0010, 1'b1, 32'hDEAD_BEEF, 3'b010);
    checks++; if (bus.io_lsu_reqValid !== 1'b1) begin errors++; $display("FAIL sw_req got=%b exp=1", bus.io_lsu_reqValid); end
    checks++; if (bus.io_lsu_addr !== 32'h3000_0010) begin errors++; $display("FAIL sw_addr got=%h exp=30000010", bus.io_lsu_addr); end
    checks++; if (bus.io_lsu_wen !== 1'b1) begin errors++; $display("FAIL sw_wen got=%b exp=1", bus.io_lsu_wen); end
    checks++; if (bus.io_lsu_wmask !== 4'b1111) begin errors++; $display("FAIL sw_wmask got=%b exp=1111", bus.io_lsu_wmask); end
    checks++; if (bus.io_lsu_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata got=%h exp=deadbeef", bus.io_lsu_wdata); end
    checks++; if (bus.io_lsu_size !== 2'b10) begin errors++; $display("FAIL sw_size got=%b exp=10", bus.io_lsu_size); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sw_in_ready got=%b exp=0", bus.in_ready); end
    step();
    checks++; if (bus.io_lsu_reqValid !== 1'b0) begin errors++; $display("FAIL sw_req_one_cycle got=%b exp=0", bus.io_lsu_reqValid); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sw_early_valid got=%b exp=0", bus.out_valid); end
    respond(32'h1234_5678);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL sw_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL sw_out_err got=%b exp=0", bus.out_err); end
    checks++; if (bus.out_rdata !== 32'h0) begin errors++; $display("FAIL sw_out_rdata got=%h exp=0", bus.out_rdata); end
    release_out();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL sw_release got valid=%b ready=%b exp 0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_store_sub();
    logic [31:0] addr_t [3] = '{32'h3000_0003, 32'h3000_0002, 32'h3000_0001};
    logic [2:0]  f3_t   [3] = '{3'b000, 3'b001, 3'b000};
    logic [31:0] wd_t   [3] = '{32'h0000_00A5, 32'hCAFE_1234, 32'h7777_775A};
    logic [3:0]  mask_t [3] = '{4'b1000, 4'b1100, 4'b0010};
    logic [31:0] exp_t  [3] = '{32'hA5A5_A5A5, 32'h1234_1234, 32'h5A5A_5A5A};
    logic [1:0]  sz_t   [3] = '{2'b00, 2'b01, 2'b00};
    for (int i = 0; i < 3; i++) begin
      issue(addr_t[i], 1'b1, wd_t[i], f3_t[i]);
      checks++; if (bus.io_lsu_wmask !== mask_t[i]) begin errors++; $display("FAIL st%0d_wmask got=%b exp=%b", i, bus.io_lsu_wmask, mask_t[i]); end
      checks++; if (bus.io_lsu_wdata !== exp_t[i]) begin errors++; $display("FAIL st%0d_wdata got=%h exp=%h", i, bus.io_lsu_wdata, exp_t[i]); end
      checks++; if (bus.io_lsu_size !== sz_t[i]) begin errors++; $display("FAIL st%0d_size got=%b exp=%b", i, bus.io_lsu_size, sz_t[i]); end
      step();
      respond(32'hFFFF_FFFF);
      release_out();
    end
  endtask

  task automatic test_loads();
    logic [31:0] addr_t [7] = '{32'h3000_0002, 32'h3000_0002, 32'h3000_0002, 32'h3000_0000,
                                32'h3000_0004, 32'h3000_0001, 32'h3000_0008};
    logic [2:0]  f3_t   [7] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010, 3'b000, 3'b011};
    logic [31:0] rd_t   [7] = '{32'h0080_0000, 32'h0080_0000, 32'hBEEF_1234, 32'h1234_8001,
                                32'h89AB_CDEF, 32'h0000_7F00, 32'hF00D_F00D};
    logic [31:0] exp_t  [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF, 32'hFFFF_8001,
                                32'h89AB_CDEF, 32'h0000_007F, 32'hF00D_F00D};
    logic [1:0]  sz_t   [7] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 2'b10};
    for (int i = 0; i < 7; i++) begin
      issue(addr_t[i], 1'b0, 32'hAAAA_AAAA, f3_t[i]);
      checks++; if (bus.io_lsu_wmask !== 4'b0000 || bus.io_lsu_wen !== 1'b0) begin errors++; $display("FAIL ld%0d_mask_wen got=%b/%b exp=0000/0", i, bus.io_lsu_wmask, bus.io_lsu_wen); end
      checks++; if (bus.io_lsu_size !== sz_t[i]) begin errors++; $display("FAIL ld%0d_size got=%b exp=%b", i, bus.io_lsu_size, sz_t[i]); end
      step();
      respond(rd_t[i]);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b0) begin errors++; $display("FAIL ld%0d_valid_err got=%b/%b exp=1/0", i, bus.out_valid, bus.out_err); end
      checks++; if (bus.out_rdata !== exp_t[i]) begin errors++; $display("FAIL ld%0d_rdata got=%h exp=%h", i, bus.out_rdata, exp_t[i]); end
      release_out();
    end
  endtask

  task automatic test_misaligned();
    issue(32'h3000_0006, 1'b0, 32'h0, 3'b010);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1) begin errors++; $display("FAIL mis_lw_valid_err got=%b/%b exp=1/1", bus.out_valid, bus.out_err); end
    checks++; if (bus.out_rdata !== 32'h0) begin errors++; $display("FAIL mis_lw_rdata got=%h exp=0", bus.out_rdata); end
    checks++; if (bus.io_lsu_reqValid !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL mis_lw_req_ready got=%b/%b exp=0/0", bus.io_lsu_reqValid, bus.in_ready); end
    step();
    checks++; if (bus.io_lsu_reqValid !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL mis_lw_hold got req=%b valid=%b exp 0/1", bus.io_lsu_reqValid, bus.out_valid); end
    release_out();
    issue(32'h3000_0003, 1'b1, 32'h1234, 3'b001);
    checks++; if (bus.out_err !== 1'b1 || bus.io_lsu_reqValid !== 1'b0) begin errors++; $display("FAIL mis_sh got err=%b req=%b exp 1/0", bus.out_err, bus.io_lsu_reqValid); end
    release_out();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mis_release got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_timeout();
    issue(32'h3000_0020, 1'b0, 32'h0, 3'b010);
    checks++; if (bus.io_lsu_reqValid !== 1'b1) begin errors++; $display("FAIL to_req got=%b exp=1", bus.io_lsu_reqValid); end
    for (int i = 0; i < 16; i++) step();
    checks++; if (bus.out_valid !== 1'b0 || bus.io_lsu_reqValid !== 1'b0) begin errors++; $display("FAIL to_early got valid=%b req=%b exp 0/0", bus.out_valid, bus.io_lsu_reqValid); end
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1) begin errors++; $display("FAIL to_expire got valid=%b err=%b exp 1/1", bus.out_valid, bus.out_err); end
    checks++; if (bus.out_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got=%h exp=0", bus.out_rdata); end
    release_out();
    respond(32'hFFFF_FFFF);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL to_late_resp got valid=%b ready=%b exp 0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_backpressure();
    issue(32'h3000_0008, 1'b0, 32'h0, 3'b010);
    step();
    respond(32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_rdata !== 32'hCAFE_F00D || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got valid=%b rdata=%h ready=%b exp 1/cafef00d/0", i, bus.out_valid, bus.out_rdata, bus.in_ready);
      end
      step();
    end
    release_out();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_async_reset();
    issue(32'h3000_0040, 1'b1, 32'h1122_3344, 3'b010);
    step();
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.io_lsu_reqValid !== 1'b0) begin
      errors++; $display("FAIL ar_ctrl got ready=%b valid=%b req=%b exp 1/0/0", bus.in_ready, bus.out_valid, bus.io_lsu_reqValid);
    end
    checks++; if (bus.io_lsu_addr !== 32'h0 || bus.io_lsu_wdata !== 32'h0 || bus.io_lsu_wmask !== 4'b0 || bus.io_lsu_wen !== 1'b0) begin
      errors++; $display("FAIL ar_bus got addr=%h wdata=%h mask=%b wen=%b exp 0", bus.io_lsu_addr, bus.io_lsu_wdata, bus.io_lsu_wmask, bus.io_lsu_wen);
    end
    checks++; if (bus.out_rdata !== 32'h0 || bus.out_err !== 1'b0) begin errors++; $display("FAIL ar_result got rdata=%h err=%b exp 0/0", bus.out_rdata, bus.out_err); end
    @(negedge clock);
    reset = 1'b1;
    step();
    respond(32'h5555_5555);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL ar_late_resp got valid=%b ready=%b exp 0/1", bus.out_valid, bus.in_ready); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_word();
    test_store_sub();
    test_loads();
    test_misaligned();
    test_timeout();
    test_backpressure();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
